game_over_monitor: RTL and testbench
====================================

# game_over_monitor

Sequential, parametrised game-over detector for the Tetris core. It replaces the single-cycle 4×4 overflow check with a generic N×N row scanner that runs one row per clock after every piece lock. It latches the game-over condition and reports its cause and the number of overflowing rows. It sits between the piece-lock logic and the top-level game FSM, which polls `game_over` and issues `restart`.

## Interface
Parameters:
- `PIECE_W`, 4: float mask is `PIECE_W`×`PIECE_W`, row-major; mask row r is bits `[r*PIECE_W +: PIECE_W]`.
- `VISIBLE_ROWS`, 20: board rows 0..`VISIBLE_ROWS`-1 are legal for settled blocks.
- `POS_W`, 5: width of `pos_y`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `restart` in 1: synchronous clear back to PLAY.
- `lock_valid` in 1: the piece locks this cycle; `pos_y`/`float` are valid.
- `pos_y` in `POS_W`: anchor row of the locking piece.
- `float` in `PIECE_W*PIECE_W`: occupancy mask of the locking piece, bit 0 = row 0 col 0.
- `spawn_valid` in 1: a new piece was spawned this cycle.
- `spawn_collide` in 1: the spawned piece overlaps settled blocks; qualified by `spawn_valid`.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when a scan completes.
- `overflow_rows` out `$clog2(PIECE_W+1)`: count of occupied mask rows above the board in the last scan.
- `game_over` out 1: latched game-over flag.
- `cause` out 2: 0 none, 1 lock overflow, 2 spawn block-out.

## Operation
- States: PLAY, SCAN, OVER.
- PLAY:
  - `lock_valid` captures `pos_y` and `float`, clears the row counter and `overflow_rows`, and moves to SCAN.
- SCAN:
  - One mask row r per cycle, r = 0..`PIECE_W`-1.
  - Row r overflows if it is non-empty and `pos_y + r >= VISIBLE_ROWS + PIECE_W - 1`.
  - The sum is computed in `POS_W+1` bits; no wrap.
  - Each overflowing row increments `overflow_rows`.
- End of scan:
  - `overflow_rows` > 0: go to OVER with `cause`=1.
  - Otherwise, if a spawn collision is pending: go to OVER with `cause`=2.
  - Otherwise: go to PLAY.
  - `done` pulses in all three cases.
- `lock_valid` while `busy` or in OVER is ignored. Upstream must wait for `busy`=0.
- Spawn check:
  - `spawn_valid & spawn_collide` in PLAY goes to OVER with `cause`=2.
  - The same condition in SCAN sets a pending flag, resolved at scan end; lock overflow has priority.
  - `lock_valid` and a spawn collision in the same PLAY cycle: scan starts and the collision is pending.
- OVER is absorbing. Only `restart` or `rst` leaves it.
- `restart` has priority over all inputs in every state. It returns to PLAY, clears the pending flag, the counter, `overflow_rows`, `game_over` and `cause`. A `lock_valid` in the same cycle is dropped.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow_rows`=0, `game_over`=0, `cause`=0, state PLAY.
- `rst` mid-scan aborts immediately; no `done` pulse is produced.
- Lock captured at edge T:
  - `busy`=1 from T to T+`PIECE_W`.
  - Rows are evaluated at edges T+1..T+`PIECE_W`.
  - After edge T+`PIECE_W`: `busy`=0, `done`=1 for one cycle, and `game_over`/`cause` are updated.
- The earliest next lock is accepted at edge T+`PIECE_W`+1.
- Spawn collision in PLAY at edge T: `game_over`=1 after edge T.
- `overflow_rows` is held from `done` until the next capture or clear.
- All outputs are registered.

## Configuration
- `GAME_OVER_SPAWN_CHECK_EN` defined: spawn block-out detection works as described above.
- `GAME_OVER_SPAWN_CHECK_EN` undefined:
  - `spawn_valid` and `spawn_collide` are ignored and the pending flag is not built.
  - `cause` is never 2.
  - Only lock overflow ends the game.

## Test plan
Defaults throughout (`PIECE_W`=4, `VISIBLE_ROWS`=20).
- Row-0 threshold: mask `16'h000F`, lock at `pos_y`=22 → `done` at +4, `game_over`=0, `overflow_rows`=0. Repeat at `pos_y`=23 → `game_over`=1, `cause`=1, `overflow_rows`=1.
- Row-3 threshold and wrap safety:
  - Mask `16'hF000`, `pos_y`=19 → no game over; `pos_y`=20 → game over, `overflow_rows`=1.
  - Mask `16'hFFFF`, `pos_y`=31 → `overflow_rows`=4, no wrap.
- Busy protocol: second `lock_valid` one cycle after the first → ignored; exactly one `done`.
- Restart mid-scan:
  - `restart` at edge T+2 → PLAY next cycle, `busy`=0, no `done`.
  - Then restart from OVER → all outputs return to reset values.
- Spawn collision (macro defined):
  - In PLAY → `game_over`=1 after 1 edge, `cause`=2.
  - During SCAN with an overflowing lock → `cause`=1.
  - With a non-overflowing lock → `cause`=2 at `done`.
- Macro undefined: same spawn stimulus → `game_over` stays 0.

Source files
------------

// File: rtl/game_over_monitor.sv
// game_over_monitor: row-sequential game-over detector (lock overflow, optional spawn block-out).
// Optional feature macro: GAME_OVER_SPAWN_CHECK_EN enables spawn block-out detection.
`default_nettype none

module game_over_monitor #(
  parameter int PIECE_W      = 4,
  parameter int VISIBLE_ROWS = 20,
  parameter int POS_W        = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         restart,
  input  logic                         lock_valid,
  input  logic [POS_W-1:0]             pos_y,
  input  logic [PIECE_W*PIECE_W-1:0]   float,
  input  logic                         spawn_valid,
  input  logic                         spawn_collide,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(PIECE_W+1)-1:0] overflow_rows,
  output logic                         game_over,
  output logic [1:0]                   cause
);

  localparam int OVF_W = $clog2(PIECE_W+1);
  localparam int ROW_W = (PIECE_W > 1) ? $clog2(PIECE_W) : 1;
  localparam logic [POS_W:0] LIMIT = (POS_W+1)'(VISIBLE_ROWS + PIECE_W - 1);

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK  = 2'd1;
  localparam logic [1:0] CAUSE_SPAWN = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic [PIECE_W*PIECE_W-1:0] mask_q, mask_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [OVF_W-1:0]           ovf_q, ovf_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       go_q, go_d;
  logic [1:0]                 cause_q, cause_d;

  logic                       w_spawn_hit;
  logic                       w_pend;
  logic [PIECE_W-1:0]         w_nz;
  logic [POS_W:0]             w_sum;
  logic                       w_last;
  logic                       w_row_ovf;
  logic [OVF_W-1:0]           w_ovf_inc;
  logic                       w_pend_eff;

  for (genvar g = 0; g < PIECE_W; g++) begin : g_row_nz
    assign w_nz[g] = |mask_q[g*PIECE_W +: PIECE_W];
  end

  // Sum is one bit wider than pos_y so high anchors never wrap below the limit.
  assign w_sum      = {1'b0, pos_q} + (POS_W+1)'(row_q);
  assign w_last     = (row_q == ROW_W'(PIECE_W-1));
  assign w_row_ovf  = w_nz[row_q] & (w_sum >= LIMIT);
  assign w_ovf_inc  = ovf_q + OVF_W'(w_row_ovf);
  assign w_pend_eff = w_pend | w_spawn_hit;

`ifdef GAME_OVER_SPAWN_CHECK_EN
  logic pend_q, pend_d;

  assign w_spawn_hit = spawn_valid & spawn_collide;
  assign w_pend      = pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    pend_d = pend_q;
    if (restart) begin
      pend_d = 1'b0;
    end else begin
      case (state_q)
        S_PLAY:  if (lock_valid) pend_d = w_spawn_hit;
        S_SCAN:  pend_d = w_last ? 1'b0 : (pend_q | w_spawn_hit);
        default: pend_d = 1'b0;
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused    = spawn_valid ^ spawn_collide;
  assign w_spawn_hit = 1'b0;
  assign w_pend      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PLAY;
      pos_q   <= '0;
      mask_q  <= '0;
      row_q   <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLAY: begin
        if (lock_valid)       state_d = S_SCAN;
        else if (w_spawn_hit) state_d = S_OVER;
      end
      S_SCAN: begin
        if (w_last) begin
          if (w_ovf_inc != '0 || w_pend_eff) state_d = S_OVER;
          else                               state_d = S_PLAY;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_PLAY;
    endcase
    if (restart) state_d = S_PLAY;
  end

  always_comb begin
    pos_d   = pos_q;
    mask_d  = mask_q;
    row_d   = row_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go_d    = go_q;
    cause_d = cause_q;
    if (restart) begin
      row_d   = '0;
      ovf_d   = '0;
      busy_d  = 1'b0;
      go_d    = 1'b0;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (lock_valid) begin
            pos_d  = pos_y;
            mask_d = float;
            row_d  = '0;
            ovf_d  = '0;
            busy_d = 1'b1;
          end else if (w_spawn_hit) begin
            go_d    = 1'b1;
            cause_d = CAUSE_SPAWN;
          end
        end
        S_SCAN: begin
          ovf_d = w_ovf_inc;
          row_d = row_q + ROW_W'(1);
          if (w_last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (w_ovf_inc != '0) begin
              go_d    = 1'b1;
              cause_d = CAUSE_LOCK;
            end else if (w_pend_eff) begin
              go_d    = 1'b1;
              cause_d = CAUSE_SPAWN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow_rows = ovf_q;
  assign game_over     = go_q;
  assign cause         = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_game_over_monitor.sv
// Self-checking bench for game_over_monitor: vector table, random locks vs. a row-count model, corner sequences.
`default_nettype none

module tb_game_over_monitor;

  localparam int PW    = 4;
  localparam int VR    = 20;
  localparam int LIMIT = VR + PW - 1;

`ifdef GAME_OVER_SPAWN_CHECK_EN
  localparam bit SPAWN_EN = 1'b1;
`else
  localparam bit SPAWN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        lock_valid = 1'b0;
  logic [4:0]  pos_y = '0;
  logic [15:0] flt = '0;
  logic        spawn_valid = 1'b0;
  logic        spawn_collide = 1'b0;
  logic        busy, done, game_over;
  logic [2:0]  overflow_rows;
  logic [1:0]  cause;

  int n_checks = 0;
  int n_fail   = 0;

  game_over_monitor #(.PIECE_W(PW), .VISIBLE_ROWS(VR), .POS_W(5)) dut (
    .clk(clk), .rst(rst), .restart(restart), .lock_valid(lock_valid),
    .pos_y(pos_y), .float(flt), .spawn_valid(spawn_valid), .spawn_collide(spawn_collide),
    .busy(busy), .done(done), .overflow_rows(overflow_rows),
    .game_over(game_over), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pos;
    logic [15:0] mask;
    int          spawn_at;   // -1 none, 0 with lock, k = held before scan edge T+k
    string       name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count mask rows that are occupied and whose board row lies above the legal area.
  function automatic int model_rows(input int p, input logic [15:0] m);
    int c = 0;
    for (int r = 0; r < PW; r++)
      if (((m >> (r*PW)) & 16'hF) != 0 && (p + r) >= LIMIT) c++;
    return c;
  endfunction

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic lock_and_check(input int p, input logic [15:0] m, input int spawn_at, input string nm);
    int  exp_rows;
    int  exp_go;
    int  exp_cause;
    bit  sp;
    exp_rows  = model_rows(p, m);
    sp        = SPAWN_EN && (spawn_at >= 0);
    exp_go    = (exp_rows > 0 || sp) ? 1 : 0;
    exp_cause = (exp_rows > 0) ? 1 : (sp ? 2 : 0);
    lock_valid    = 1'b1;
    pos_y         = p[4:0];
    flt           = m;
    spawn_valid   = (spawn_at == 0);
    spawn_collide = (spawn_at == 0);
    tick();
    lock_valid    = 1'b0;
    spawn_valid   = 1'b0;
    spawn_collide = 1'b0;
    chk({nm, "_busy_start"}, busy, 1);
    for (int k = 1; k <= PW; k++) begin
      if (spawn_at == k) begin
        spawn_valid   = 1'b1;
        spawn_collide = 1'b1;
      end
      tick();
      spawn_valid   = 1'b0;
      spawn_collide = 1'b0;
      if (k < PW) chk({nm, "_done_early"}, done, 0);
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_rows"}, overflow_rows, exp_rows);
    chk({nm, "_game_over"}, game_over, exp_go);
    chk({nm, "_cause"}, cause, exp_cause);
    tick();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_rows_held"}, overflow_rows, exp_rows);
  endtask

  vec_t vecs[$];

  initial begin
    int dones;
    vecs.push_back('{22, 16'h000F, -1, "row0_22"});
    vecs.push_back('{23, 16'h000F, -1, "row0_23"});
    vecs.push_back('{19, 16'hF000, -1, "row3_19"});
    vecs.push_back('{20, 16'hF000, -1, "row3_20"});
    vecs.push_back('{31, 16'hFFFF, -1, "full_31"});
    vecs.push_back('{21, 16'h0F0F, -1, "mixed_21"});
    vecs.push_back('{0,  16'h0000, -1, "empty_0"});
    vecs.push_back('{25, 16'h0000, -1, "empty_25"});
    vecs.push_back('{23, 16'hFFFF,  2, "spawn_ovf"});
    vecs.push_back('{5,  16'h00F0,  1, "spawn_noovf"});
    vecs.push_back('{5,  16'h00F0,  0, "spawn_same"});

    // Reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rows", overflow_rows, 0);
    chk("rst_go", game_over, 0);
    chk("rst_cause", cause, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      lock_and_check(vecs[i].pos, vecs[i].mask, vecs[i].spawn_at, vecs[i].name);
      do_restart();
    end

    // Randomized locks against the row-count model
    for (int i = 0; i < 40; i++) begin
      int          p;
      int          sa;
      logic [15:0] m;
      p  = $urandom_range(0, 31);
      m  = 16'($urandom) & 16'($urandom);
      sa = $urandom_range(0, 5) - 1;
      if (sa > 3) sa = -1;
      lock_and_check(p, m, sa, "rand");
      do_restart();
    end

    // Second lock one cycle after the first must be ignored
    lock_valid = 1'b1; pos_y = 5'd0; flt = 16'hFFFF;
    tick();
    pos_y = 5'd31;
    tick();
    lock_valid = 1'b0;
    dones = (done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("busy_proto_dones", dones, 1);
    chk("busy_proto_go", game_over, 0);
    chk("busy_proto_rows", overflow_rows, 0);

    // Restart at edge T+2 aborts the scan
    lock_valid = 1'b1; pos_y = 5'd31; flt = 16'hFFFF;
    tick();
    lock_valid = 1'b0;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_mid_busy", busy, 0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("rs_mid_dones", dones, 0);
    chk("rs_mid_go", game_over, 0);

    // Restart from OVER restores reset outputs; a same-cycle lock is dropped
    lock_and_check(30, 16'hFFFF, -1, "to_over");
    lock_valid = 1'b1; pos_y = 5'd31; flt = 16'hFFFF;
    tick();
    lock_valid = 1'b0;
    chk("over_absorb_busy", busy, 0);
    restart = 1'b1; lock_valid = 1'b1;
    tick();
    restart = 1'b0; lock_valid = 1'b0;
    chk("rs_over_busy", busy, 0);
    chk("rs_over_done", done, 0);
    chk("rs_over_rows", overflow_rows, 0);
    chk("rs_over_go", game_over, 0);
    chk("rs_over_cause", cause, 0);
    tick();
    chk("rs_drop_busy", busy, 0);

    // Spawn collision while idle
    spawn_valid = 1'b1; spawn_collide = 1'b1;
    tick();
    spawn_valid = 1'b0; spawn_collide = 1'b0;
    chk("spawn_play_go", game_over, SPAWN_EN ? 1 : 0);
    chk("spawn_play_cause", cause, SPAWN_EN ? 2 : 0);
    do_restart();
    spawn_valid = 1'b1; spawn_collide = 1'b0;
    tick();
    spawn_valid = 1'b0;
    chk("spawn_nocollide_go", game_over, 0);

    // Asynchronous reset mid-scan: immediate abort, no done
    lock_valid = 1'b1; pos_y = 5'd31; flt = 16'hFFFF;
    tick();
    lock_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1 chk("rst_mid_busy", busy, 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("rst_mid_dones", dones, 0);
    chk("rst_mid_go", game_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
